shift_ring_counter: RTL and testbench

Parametrised successor to the team's fixed 4-bit flip-flop ring counter. Provides a WIDTH-bit ring or Johnson (twisted-ring) shifter, clocked by the system clock, with a selectable shift direction and synchronous parallel load. Advances on a synchronised, edge-detected step request, typically a pushbutton. Also reports the step position within the sequence period and a wrap pulse, and drives LED/display logic in the top level.

---
 rtl/shift_ring_pkg.sv | 19 +
 rtl/step_sync.sv | 28 ++
 rtl/shift_ring_counter.sv | 106 ++++++++++
 tb/tb_shift_ring_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shift_ring_pkg.sv
// Shared types and helpers for the shift_ring_counter block.
package shift_ring_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Sequence period: a ring visits WIDTH states, a Johnson counter 2*WIDTH.
    function automatic int unsigned period(input mode_e m, input int unsigned width);
        return (m == MODE_JOHNSON) ? 2 * width : width;
    endfunction

endpackage

// File: rtl/step_sync.sv
// Synchroniser for the raw step request followed by a rising-edge detector.
// pulse is high for exactly one hz100 cycle per rising edge of async_in.
module step_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic hz100,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw input through the synchroniser and remember the last synced value.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/shift_ring_counter.sv
// WIDTH-bit ring / Johnson shifter advanced by a synchronised step request.
// Reports position within the sequence period and a wrap pulse.
// Optional feature: define SHIFT_RING_SELFCORRECT_EN to reseed ring mode
// with INIT whenever q is not one-hot at a step.
module shift_ring_counter
    import shift_ring_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] INIT        = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               SYNC_STAGES = 2
) (
    input  logic                          hz100,
    input  logic                          reset,
    input  logic                          step,
    input  logic                          dir,
    input  logic                          mode,
    input  logic                          load,
    input  logic [WIDTH-1:0]              load_val,
    output logic [WIDTH-1:0]              q,
    output logic [$clog2(2*WIDTH)-1:0]    pos,
    output logic                          wrap
);

    localparam int PW = $clog2(2*WIDTH);

    logic             stp;
    mode_e            mode_n;
    mode_e            mode_r;
    dir_e             dir_n;
    logic [WIDTH-1:0] shift_q;
    logic             reseed;
    logic [PW-1:0]    pos_last;
    logic [PW-1:0]    pos_nx;

    step_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_step_sync (
        .hz100    (hz100),
        .reset    (reset),
        .async_in (step),
        .pulse    (stp)
    );

    assign mode_n = mode_e'(mode);
    assign dir_n  = dir_e'(dir);

    // Next shifter value for the mode/direction presented this cycle.
    always_comb begin
        shift_q = q;
        reseed  = 1'b0;
        unique case ({mode_n, dir_n})
            {MODE_RING,    DIR_UP}:   shift_q = {q[WIDTH-2:0], q[WIDTH-1]};
            {MODE_RING,    DIR_DOWN}: shift_q = {q[0], q[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_UP}:   shift_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
            {MODE_JOHNSON, DIR_DOWN}: shift_q = {~q[0], q[WIDTH-1:1]};
            default:                  shift_q = q;
        endcase
`ifdef SHIFT_RING_SELFCORRECT_EN
        if (mode_n == MODE_RING && $countones(q) != 1) begin
            shift_q = INIT;
            reseed  = 1'b1;
        end
`endif
    end

    // Position bookkeeping modulo the current period.
    always_comb begin
        pos_last = PW'(period(mode_n, WIDTH) - 1);
        pos_nx   = pos;
        if (dir_n == DIR_UP)
            pos_nx = (pos == pos_last) ? '0 : pos + 1'b1;
        else
            pos_nx = (pos == '0) ? pos_last : pos - 1'b1;
    end

    // Load beats mode change, mode change beats a counted step.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            q      <= INIT;
            pos    <= '0;
            wrap   <= 1'b0;
            mode_r <= MODE_RING;
        end else begin
            mode_r <= mode_n;
            wrap   <= 1'b0;
            if (load) begin
                q   <= load_val;
                pos <= '0;
            end else if (mode_n != mode_r) begin
                // A step landing on a mode change still shifts, but restarts the count.
                pos <= '0;
                if (stp)
                    q <= shift_q;
            end else if (stp) begin
                q <= shift_q;
                if (reseed) begin
                    pos <= '0;
                end else begin
                    pos  <= pos_nx;
                    wrap <= (pos_nx == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Self-checking bench for shift_ring_counter (WIDTH=4, INIT=4'b0001).
module tb_shift_ring_counter;

    logic       hz100 = 1'b0;
    logic       reset;
    logic       step;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic [2:0] pos;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    logic [3:0] cur_q;
    logic [2:0] cur_pos;

    typedef struct {
        logic [3:0] q;
        logic [2:0] pos;
        logic       wrap;
    } exp_t;

    typedef struct {
        logic       dir;
        logic       mode;
        logic [3:0] q;
        logic [2:0] pos;
        logic       wrap;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    shift_ring_counter #(
        .WIDTH       (4),
        .INIT        (4'b0001),
        .SYNC_STAGES (2)
    ) dut (
        .hz100    (hz100),
        .reset    (reset),
        .step     (step),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .pos      (pos),
        .wrap     (wrap)
    );

    always #5 hz100 = ~hz100;

    task automatic chk(input string nm, input logic [3:0] eq, input logic [2:0] ep, input logic ew);
        checks++;
        if (q !== eq || pos !== ep || wrap !== ew) begin
            errors++;
            $display("FAIL %s: got q=%b pos=%0d wrap=%b, need q=%b pos=%0d wrap=%b",
                     nm, q, pos, wrap, eq, ep, ew);
        end
    endtask

    // One step request; result must appear exactly at the third edge.
    task automatic do_step(input string nm, input logic [3:0] eq, input logic [2:0] ep, input logic ew);
        exp_t e;
        exp_t got;
        @(negedge hz100);
        step = 1'b1;
        e.q = eq; e.pos = ep; e.wrap = ew;
        sb.push_back(e);
        @(negedge hz100);
        @(negedge hz100);
        chk({nm, "_early"}, cur_q, cur_pos, 1'b0);
        step = 1'b0;
        @(negedge hz100);
        got = sb.pop_front();
        chk(nm, got.q, got.pos, got.wrap);
        cur_q   = got.q;
        cur_pos = got.pos;
        @(negedge hz100);
        chk({nm, "_after"}, cur_q, cur_pos, 1'b0);
        repeat (3) @(negedge hz100);
    endtask

    task automatic do_load(input string nm, input logic [3:0] v, input logic m);
        @(negedge hz100);
        load     = 1'b1;
        load_val = v;
        mode     = m;
        @(negedge hz100);
        load = 1'b0;
        chk(nm, v, 3'd0, 1'b0);
        cur_q   = v;
        cur_pos = 3'd0;
    endtask

    initial begin
        // dir, mode, q, pos, wrap
        vecs[0]  = '{1'b0, 1'b0, 4'b0010, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'b0100, 3'd2, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'b1000, 3'd3, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'b0001, 3'd0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 4'b1000, 3'd3, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'b0001, 3'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'b0011, 3'd2, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'b0111, 3'd3, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'b1111, 3'd4, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'b1110, 3'd5, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'b1100, 3'd6, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'b1000, 3'd7, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 4'b0000, 3'd0, 1'b1};

        reset = 1'b1; step = 1'b0; dir = 1'b0; mode = 1'b0;
        load = 1'b0; load_val = 4'b0000;
        #12;
        chk("reset", 4'b0001, 3'd0, 1'b0);
        @(negedge hz100);
        reset = 1'b0;
        cur_q = 4'b0001; cur_pos = 3'd0;
        @(negedge hz100);
        chk("reset_release", 4'b0001, 3'd0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            if (i == 5)
                do_load("load_johnson", 4'b0000, 1'b1);
            @(negedge hz100);
            dir  = vecs[i].dir;
            mode = vecs[i].mode;
            do_step($sformatf("vec%0d", i), vecs[i].q, vecs[i].pos, vecs[i].wrap);
        end

        // Held step: only one shift.
        dir = 1'b0;
        do_load("load_ring", 4'b0001, 1'b0);
        @(negedge hz100);
        step = 1'b1;
        repeat (50) @(negedge hz100);
        chk("hold_50", 4'b0010, 3'd1, 1'b0);
        step = 1'b0;
        repeat (5) @(negedge hz100);
        chk("hold_release", 4'b0010, 3'd1, 1'b0);

        // Load coincident with the step pulse: load wins, step discarded.
        @(negedge hz100);
        step = 1'b1;
        @(negedge hz100);
        @(negedge hz100);
        load = 1'b1; load_val = 4'b1010; step = 1'b0;
        @(negedge hz100);
        load = 1'b0;
        chk("load_vs_stp", 4'b1010, 3'd0, 1'b0);
        @(negedge hz100);
        chk("load_vs_stp_hold", 4'b1010, 3'd0, 1'b0);

        // Mode change coincident with the step pulse: shift in new mode, not counted.
        do_load("load_ring2", 4'b0001, 1'b0);
        do_step("ring_pre_mode", 4'b0010, 3'd1, 1'b0);
        @(negedge hz100);
        step = 1'b1;
        @(negedge hz100);
        @(negedge hz100);
        mode = 1'b1; step = 1'b0;
        @(negedge hz100);
        chk("mode_vs_stp", 4'b0101, 3'd0, 1'b0);
        cur_q = 4'b0101; cur_pos = 3'd0;
        repeat (3) @(negedge hz100);
        do_step("johnson_after_mode", 4'b1011, 3'd1, 1'b0);

        // Multi-hot ring pattern.
        do_load("load_0110", 4'b0110, 1'b0);
`ifdef SHIFT_RING_SELFCORRECT_EN
        do_step("multihot", 4'b0001, 3'd0, 1'b0);
        do_step("multihot_next", 4'b0010, 3'd1, 1'b0);
`else
        do_step("multihot", 4'b1100, 3'd1, 1'b0);
        do_step("multihot_next", 4'b1001, 3'd2, 1'b0);
`endif

        // Async reset mid-count, no clock edge between assert and check.
        @(posedge hz100);
        #3 reset = 1'b1;
        #1 chk("reset_async", 4'b0001, 3'd0, 1'b0);
        @(negedge hz100);
        reset = 1'b0;
        cur_q = 4'b0001; cur_pos = 3'd0;
        do_step("post_reset", 4'b0010, 3'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
